// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, FSM states and step count for the HI/LO multiply/divide controller
package muldiv_pkg;
    typedef enum logic [2:0] {
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_RSV6, OP_RSV7
    } muldiv_op_t;
    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} muldiv_state_t;
    localparam int MULDIV_STEPS = 32;
endpackage

// File: rtl/muldiv_shift_datapath.sv
// muldiv_shift_datapath: one-bit-per-cycle shift-add multiply / restoring divide on unsigned magnitudes
module muldiv_shift_datapath #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic           step,
    input  logic           is_div,
    input  logic [W-1:0]   a_mag,
    input  logic [W-1:0]   b_mag,
    output logic [2*W-1:0] raw_result,
    output logic           div_carry
);
    logic [W-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d, hi_step, lo_step;
    logic [W:0]   add, shl, diff;
    // raw_result is the post-step value so the last step can be registered straight into the outputs
    always_comb begin
        add        = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        shl        = {hi_q, lo_q[W-1]};
        diff       = shl - {1'b0, m_q};
        div_carry  = !diff[W];
        hi_step    = is_div ? (div_carry ? diff[W-1:0] : shl[W-1:0]) : add[W:1];
        lo_step    = is_div ? {lo_q[W-2:0], div_carry} : {add[0], lo_q[W-1:1]};
        raw_result = {hi_step, lo_step};
        hi_d       = load ? '0 : step ? hi_step : hi_q;
        lo_d       = load ? a_mag : step ? lo_step : lo_q;
        m_d        = load ? b_mag : m_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
            m_q  <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            m_q  <= m_d;
        end
    end
endmodule

// File: rtl/hilo_muldiv_controller.sv
// hilo_muldiv_controller: sequences MULT/MULTU/DIV/DIVU/MTHI/MTLO into paired HI/LO write pulses
import muldiv_pkg::*;
module hilo_muldiv_controller #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] DIV0_LO = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             op_ready,
    input  logic             mfhilo_request,
    output logic             stall,
    output logic             busy,
    output logic             HI_write_enable,
    output logic             LO_write_enable,
    output logic [WIDTH-1:0] HI_write_data,
    output logic [WIDTH-1:0] LO_write_data
);
    muldiv_state_t      state_q, state_d;
    muldiv_op_t         op;
    logic [5:0]         cnt_q, cnt_d;
    logic               neg_q, neg_d, rneg_q, rneg_d;
    logic               hi_we_q, hi_we_d, lo_we_q, lo_we_d;
    logic [WIDTH-1:0]   hi_data_q, hi_data_d, lo_data_q, lo_data_d;
    logic               accept, sgn, mul_op, div_op, load, step, is_div, last, unused_div_carry;
    logic [WIDTH-1:0]   a_mag, b_mag, quo, rem;
    logic [2*WIDTH-1:0] raw_result, prod;

    muldiv_shift_datapath #(.W(WIDTH)) u_dp (
        .clk(clk), .reset(reset), .load(load), .step(step), .is_div(is_div),
        .a_mag(a_mag), .b_mag(b_mag), .raw_result(raw_result), .div_carry(unused_div_carry)
    );

    always_comb begin
        op        = muldiv_op_t'(op_code);
        accept    = op_valid && state_q == ST_IDLE;
        sgn       = op == OP_MULT || op == OP_DIV;
        mul_op    = op == OP_MULT || op == OP_MULTU;
        div_op    = op == OP_DIV || op == OP_DIVU;
        a_mag     = (sgn && operand_a[WIDTH-1]) ? -operand_a : operand_a;
        b_mag     = (sgn && operand_b[WIDTH-1]) ? -operand_b : operand_b;
        load      = accept && (mul_op || (div_op && operand_b != '0));
        step      = state_q == ST_MUL || state_q == ST_DIV;
        is_div    = state_q == ST_DIV;
        last      = cnt_q == 6'(MULDIV_STEPS - 1);
        prod      = neg_q ? -raw_result : raw_result;
        quo       = neg_q ? -raw_result[WIDTH-1:0] : raw_result[WIDTH-1:0];
        rem       = rneg_q ? -raw_result[2*WIDTH-1:WIDTH] : raw_result[2*WIDTH-1:WIDTH];
        state_d   = state_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        hi_we_d   = 1'b0;
        lo_we_d   = 1'b0;
        hi_data_d = hi_data_q;
        lo_data_d = lo_data_q;
        if (accept && op == OP_MTHI) begin
            hi_we_d   = 1'b1;
            hi_data_d = operand_a;
        end
        if (accept && op == OP_MTLO) begin
            lo_we_d   = 1'b1;
            lo_data_d = operand_a;
        end
        if (accept && (mul_op || div_op)) begin
            neg_d  = sgn && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
            rneg_d = sgn && operand_a[WIDTH-1];
            cnt_d  = '0;
            state_d = mul_op ? ST_MUL : load ? ST_DIV : ST_DONE;
        end
        // divide-by-zero skips the iteration and writes its fixed result immediately
        if (accept && div_op && !load) begin
            hi_we_d   = 1'b1;
            lo_we_d   = 1'b1;
            hi_data_d = operand_a;
            lo_data_d = DIV0_LO;
        end
        if (step) begin
            cnt_d = cnt_q + 6'd1;
            if (last) begin
                state_d   = ST_DONE;
                cnt_d     = '0;
                hi_we_d   = 1'b1;
                lo_we_d   = 1'b1;
                hi_data_d = is_div ? rem : prod[2*WIDTH-1:WIDTH];
                lo_data_d = is_div ? quo : prod[WIDTH-1:0];
            end
        end
        if (state_q == ST_DONE) state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            hi_we_q   <= 1'b0;
            lo_we_q   <= 1'b0;
            hi_data_q <= '0;
            lo_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
            hi_we_q   <= hi_we_d;
            lo_we_q   <= lo_we_d;
            hi_data_q <= hi_data_d;
            lo_data_q <= lo_data_d;
        end
    end

    assign op_ready        = state_q == ST_IDLE;
    assign busy            = state_q != ST_IDLE;
    assign stall           = mfhilo_request && (busy || hi_we_q || lo_we_q);
    assign HI_write_enable = hi_we_q;
    assign LO_write_enable = lo_we_q;
    assign HI_write_data   = hi_data_q;
    assign LO_write_data   = lo_data_q;
endmodule
